// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: owns PC, decodes the 10 instruction bytes and loads the F->D register; optional FETCH_PERF_EN adds counters.
// Latency: 1 cycle from PC to D register. Backpressure: stall holds PC/D/state; redirect overrides stall.
module fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int unsigned IMEM_LAST = 144
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [63:0] PC,
    input  logic [7:0]  valRead0,
    input  logic [7:0]  valRead1,
    input  logic [7:0]  valRead2,
    input  logic [7:0]  valRead3,
    input  logic [7:0]  valRead4,
    input  logic [7:0]  valRead5,
    input  logic [7:0]  valRead6,
    input  logic [7:0]  valRead7,
    input  logic [7:0]  valRead8,
    input  logic [7:0]  valRead9,
    input  logic        imem_error,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        D_valid,
    output logic [2:0]  D_stat,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`endif
);

    typedef enum logic [1:0] {S_RUN, S_WAIT_RET, S_HALTED} state_t;

    typedef struct packed {
        logic        valid;
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } dreg_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam dreg_t BUBBLE = '{valid: 1'b0, stat: STAT_AOK, icode: 4'h1, ifun: 4'h0,
                                 ra: 4'hF, rb: 4'hF, valc: 64'd0, valp: 64'd0};

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    dreg_t       d_q, d_d;

    logic [3:0]  f_icode, f_ifun, f_len;
    logic        f_regids, f_ifun_ok;
    logic [63:0] f_valc, f_valp, f_pred;
    logic [64:0] f_end;
    logic [2:0]  f_stat;
    dreg_t       f_inst;

    always_comb begin
        f_icode   = valRead0[7:4];
        f_ifun    = valRead0[3:0];
        f_len     = 4'd1;
        f_regids  = 1'b0;
        f_valc    = 64'd0;
        f_ifun_ok = (f_ifun == 4'h0);
        case (f_icode)
            4'h2, 4'h6, 4'hA, 4'hB: begin f_len = 4'd2;  f_regids = 1'b1; end
            4'h3, 4'h4, 4'h5:       begin f_len = 4'd10; f_regids = 1'b1; end
            4'h7, 4'h8:             f_len = 4'd9;
            default:                f_len = 4'd1;
        endcase
        case (f_icode)
            4'h3, 4'h4, 4'h5: f_valc = {valRead9, valRead8, valRead7, valRead6,
                                        valRead5, valRead4, valRead3, valRead2};
            4'h7, 4'h8:       f_valc = {valRead8, valRead7, valRead6, valRead5,
                                        valRead4, valRead3, valRead2, valRead1};
            default:          f_valc = 64'd0;
        endcase
        case (f_icode)
            4'h6:       f_ifun_ok = (f_ifun <= 4'h3);
            4'h2, 4'h7: f_ifun_ok = (f_ifun <= 4'h6);
            4'hC, 4'hD, 4'hE, 4'hF: f_ifun_ok = 1'b0;
            default:    f_ifun_ok = (f_ifun == 4'h0);
        endcase
        f_valp = pc_q + 64'(f_len);
        // 65-bit end address so a fetch near the top of the space cannot wrap past the check
        f_end  = {1'b0, pc_q} + 65'(f_len) - 65'd1;
        if (imem_error || (f_end > 65'(IMEM_LAST)))
            f_stat = STAT_ADR;
        else if (!f_ifun_ok)
            f_stat = STAT_INS;
        else if (f_icode == 4'h0)
            f_stat = STAT_HLT;
        else
            f_stat = STAT_AOK;
        f_pred = ((f_icode == 4'h7) || (f_icode == 4'h8)) ? f_valc : f_valp;

        f_inst.valid = 1'b1;
        f_inst.stat  = f_stat;
        f_inst.icode = f_icode;
        f_inst.ifun  = f_ifun;
        f_inst.ra    = f_regids ? valRead1[7:4] : 4'hF;
        f_inst.rb    = f_regids ? valRead1[3:0] : 4'hF;
        f_inst.valc  = f_valc;
        f_inst.valp  = f_valp;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        d_d     = d_q;
        if (redirect) begin
            state_d = S_RUN;
            pc_d    = redirect_pc;
            d_d     = BUBBLE;
        end else if (!stall) begin
            if (state_q == S_RUN) begin
                d_d = f_inst;
                if (f_stat != STAT_AOK) begin
                    state_d = S_HALTED;
                end else if (f_icode == 4'h9) begin
                    // ret target comes back via redirect; PC parks at valP and is not fetched from
                    state_d = S_WAIT_RET;
                    pc_d    = f_valp;
                end else begin
                    pc_d = f_pred;
                end
            end else begin
                d_d = BUBBLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            d_q     <= BUBBLE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            d_q     <= d_d;
        end
    end

    assign PC      = pc_q;
    assign D_valid = d_q.valid;
    assign D_stat  = d_q.stat;
    assign D_icode = d_q.icode;
    assign D_ifun  = d_q.ifun;
    assign D_rA    = d_q.ra;
    assign D_rB    = d_q.rb;
    assign D_valC  = d_q.valc;
    assign D_valP  = d_q.valp;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_bubbles_q, perf_bubbles_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_bubbles_d = perf_bubbles_q;
        if (redirect || (!stall && state_q != S_RUN))
            perf_bubbles_d = perf_bubbles_q + 32'd1;
        else if (!stall)
            perf_fetched_d = perf_fetched_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched_q <= 32'd0;
            perf_bubbles_q <= 32'd0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_bubbles_q <= perf_bubbles_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: instruction-level reference model checked every cycle, plus literal expectations.
module tb_fetch_stage;

    localparam logic [63:0] RST_PC = 64'h0;
    localparam int          LAST   = 144;

    logic        clk;
    logic        reset_n;
    logic [63:0] PC;
    logic [7:0]  valRead0, valRead1, valRead2, valRead3, valRead4;
    logic [7:0]  valRead5, valRead6, valRead7, valRead8, valRead9;
    logic        imem_error, stall, redirect;
    logic [63:0] redirect_pc;
    logic        D_valid;
    logic [2:0]  D_stat;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_bubbles;
`endif

    int checks;
    int failures;
    logic cmp_en;

    fetch_stage #(.RESET_PC(RST_PC), .IMEM_LAST(LAST)) dut (
        .clk(clk), .reset_n(reset_n), .PC(PC),
        .valRead0(valRead0), .valRead1(valRead1), .valRead2(valRead2), .valRead3(valRead3),
        .valRead4(valRead4), .valRead5(valRead5), .valRead6(valRead6), .valRead7(valRead7),
        .valRead8(valRead8), .valRead9(valRead9),
        .imem_error(imem_error), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .D_valid(D_valid), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
        .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:255];

    function automatic logic [7:0] mem_rd(input logic [63:0] a);
        return (a < 64'd256) ? mem[a[7:0]] : 8'h00;
    endfunction

    assign valRead0 = mem_rd(PC);
    assign valRead1 = mem_rd(PC + 64'd1);
    assign valRead2 = mem_rd(PC + 64'd2);
    assign valRead3 = mem_rd(PC + 64'd3);
    assign valRead4 = mem_rd(PC + 64'd4);
    assign valRead5 = mem_rd(PC + 64'd5);
    assign valRead6 = mem_rd(PC + 64'd6);
    assign valRead7 = mem_rd(PC + 64'd7);
    assign valRead8 = mem_rd(PC + 64'd8);
    assign valRead9 = mem_rd(PC + 64'd9);

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        valid;
        logic [2:0]  stat;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
    } dview_t;

    localparam dview_t BUB = {1'b0, 3'd1, 4'd1, 4'd0, 4'hF, 4'hF, 64'd0, 64'd0};
    localparam int LEN_TAB [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
    localparam int MAX_FN  [16] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0, -1, -1, -1, -1};
    localparam logic [15:0] HAS_REG = 16'h0C7C;

    function automatic dview_t model_fetch(input logic [63:0] pc, input logic err);
        dview_t      r;
        logic [7:0]  b [10];
        int          ic, fn;
        logic [64:0] last_byte;
        for (int k = 0; k < 10; k++) b[k] = mem_rd(pc + 64'(k));
        ic = int'(b[0][7:4]);
        fn = int'(b[0][3:0]);
        r.valid = 1'b1;
        r.icode = b[0][7:4];
        r.ifun  = b[0][3:0];
        r.ra    = HAS_REG[ic] ? b[1][7:4] : 4'hF;
        r.rb    = HAS_REG[ic] ? b[1][3:0] : 4'hF;
        r.valc  = 64'd0;
        for (int k = 0; k < 8; k++) begin
            if (ic >= 3 && ic <= 5) r.valc = r.valc | (64'(b[k + 2]) << (8 * k));
            if (ic == 7 || ic == 8) r.valc = r.valc | (64'(b[k + 1]) << (8 * k));
        end
        r.valp    = pc + 64'(LEN_TAB[ic]);
        last_byte = {1'b0, pc} + 65'(LEN_TAB[ic]) - 65'd1;
        if (err || last_byte > 65'(LAST)) r.stat = 3'd3;
        else if (fn > MAX_FN[ic])         r.stat = 3'd4;
        else if (ic == 0)                 r.stat = 3'd2;
        else                              r.stat = 3'd1;
        return r;
    endfunction

    logic [63:0] m_pc;
    logic        m_blocked;
    dview_t      m_d, mf;
    logic [63:0] mpred;
    int unsigned m_fet, m_bub;

    always @* begin
        mf    = model_fetch(m_pc, imem_error);
        mpred = (mf.icode == 4'h7 || mf.icode == 4'h8) ? mf.valc : mf.valp;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pc <= RST_PC; m_blocked <= 1'b0; m_d <= BUB; m_fet <= 0; m_bub <= 0;
        end else if (redirect) begin
            m_pc <= redirect_pc; m_blocked <= 1'b0; m_d <= BUB; m_bub <= m_bub + 1;
        end else if (!stall) begin
            if (m_blocked) begin
                m_d <= BUB; m_bub <= m_bub + 1;
            end else begin
                m_d <= mf; m_fet <= m_fet + 1;
                if (mf.stat != 3'd1)         m_blocked <= 1'b1;
                else if (mf.icode == 4'h9) begin m_blocked <= 1'b1; m_pc <= mf.valp; end
                else                         m_pc <= mpred;
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (cmp_en) begin
            checks++;
            if ({D_valid, D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP} !== m_d || PC !== m_pc) begin
                failures++;
                $display("FAIL model_cmp t=%0t got pc=%h d=%h expected pc=%h d=%h", $time, PC,
                         {D_valid, D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP}, m_pc, m_d);
            end
`ifdef FETCH_PERF_EN
            checks++;
            if (perf_fetched !== m_fet || perf_bubbles !== m_bub) begin
                failures++;
                $display("FAIL perf_cmp got fetched=%0d bubbles=%0d expected %0d %0d",
                         perf_fetched, perf_bubbles, m_fet, m_bub);
            end
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [63:0] target);
        redirect = 1'b1; redirect_pc = target;
        tick();
        redirect = 1'b0;
    endtask

    task automatic put(input int addr, input logic [79:0] bytes_msb_first, input int n);
        for (int k = 0; k < n; k++) mem[addr + k] = bytes_msb_first[79 - 8 * k -: 8];
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        put(8'h00, 80'h30F20A00000000000000, 10);  // irmovq $10,%rdx
        put(8'h0A, 80'h70400000000000000000, 9);   // jmp 0x40
        put(8'h40, 80'h90000000000000000000, 1);   // ret
        put(8'h20, 80'hC0000000000000000000, 1);   // bad icode
        put(8'h30, 80'h00000000000000000000, 1);   // halt
        put(8'h50, 80'h60232012A00F00000000, 6);   // addq, rrmovq, pushq
        put(8'h56, 80'h50120800000000000000, 10);  // mrmovq 8(%rdx)
        put(8'h60, 80'h80700000000000000000, 9);   // call 0x70
        put(8'h70, 80'h10263464000000000000, 4);   // nop, cmovg, OPq ifun 4
        put(140,   80'h30F30100000000000000, 10);  // irmovq running past IMEM_LAST

        checks = 0; failures = 0; cmp_en = 1'b0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 64'd0; imem_error = 1'b0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1 cmp_en = 1'b1;
        tick(); tick();
        chk("rst_pc", PC, 64'd0);
        chk("rst_valid", 64'(D_valid), 64'd0);
        chk("rst_icode", 64'(D_icode), 64'd1);
        chk("rst_stat", 64'(D_stat), 64'd1);
        reset_n = 1'b1;

        tick();
        chk("irmov_icode", 64'(D_icode), 64'd3);
        chk("irmov_rA", 64'(D_rA), 64'hF);
        chk("irmov_rB", 64'(D_rB), 64'd2);
        chk("irmov_valC", D_valC, 64'd10);
        chk("irmov_valP", D_valP, 64'd10);
        chk("irmov_pc", PC, 64'd10);
        tick();
        chk("jmp_valC", D_valC, 64'h40);
        chk("jmp_valP", D_valP, 64'd19);
        chk("jmp_pc", PC, 64'h40);
        tick();
        chk("ret_icode", 64'(D_icode), 64'd9);
        tick(); tick(); tick();
        chk("ret_wait_valid", 64'(D_valid), 64'd0);
        chk("ret_wait_pc", PC, 64'h41);
        do_redirect(64'h20);
        chk("ret_redir_pc", PC, 64'h20);

        tick();
        chk("ins_stat", 64'(D_stat), 64'd4);
        chk("ins_valid", 64'(D_valid), 64'd1);
        tick(); tick();
        chk("halted_valid", 64'(D_valid), 64'd0);
        chk("halted_pc", PC, 64'h20);
        do_redirect(64'h50);

        tick(); tick();
        stall = 1'b1;
        tick(); tick(); tick();
        chk("stall_pc", PC, 64'h54);
        chk("stall_icode", 64'(D_icode), 64'd2);
        stall = 1'b0;
        tick(); tick();
        stall = 1'b1;
        do_redirect(64'h60);
        stall = 1'b0;
        chk("stall_redir_pc", PC, 64'h60);
        chk("stall_redir_valid", 64'(D_valid), 64'd0);
        tick();
        chk("call_valC", D_valC, 64'h70);
        chk("call_valP", D_valP, 64'h69);
        tick(); tick(); tick();
        chk("opq_bad_ifun", 64'(D_stat), 64'd4);
        tick();

        do_redirect(64'd140);
        tick();
        chk("adr_stat", 64'(D_stat), 64'd3);
        chk("adr_pc", PC, 64'd140);
        tick();
        do_redirect(64'h30);
        tick();
        chk("hlt_stat", 64'(D_stat), 64'd2);
        tick();
        do_redirect(64'h0);
        imem_error = 1'b1;
        tick();
        imem_error = 1'b0;
        chk("imem_err_stat", 64'(D_stat), 64'd3);

        do_redirect(64'h0);
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_pc", PC, 64'd0);
        chk("async_rst_valid", 64'(D_valid), 64'd0);
        chk("async_rst_valP", D_valP, 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_icode", 64'(D_icode), 64'd3);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
